// File: rtl/segment_transition_ctl_pkg.sv
// Shared types for the segment transition controller: transition mode codes,
// sequencer states and the repeat-count "infinite" sentinel.
package segment_transition_ctl_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX  = 8'h00,
    TRANSITION_MODE_SYS_TIME  = 8'h01,
    TRANSITION_MODE_GPIO      = 8'h02,
    TRANSITION_MODE_EXT       = 8'hF0,
    TRANSITION_MODE_IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_SYNC,
    WAIT_TIME,
    WAIT_GPIO
  } seg_trans_state_t;

  // Truncated to RepWidth at the point of use; all-ones means loop forever.
  localparam logic [63:0] RepInfinite = '1;

  function automatic logic mode_known(input logic [7:0] m);
    return m inside {TRANSITION_MODE_SYNC_IDX, TRANSITION_MODE_SYS_TIME,
                     TRANSITION_MODE_GPIO, TRANSITION_MODE_EXT,
                     TRANSITION_MODE_IMMEDIATE};
  endfunction

endpackage

// File: rtl/segment_rep_counter.sv
// Per-segment repeat counter: loads the loop count, decrements per loop end,
// and flags the infinite sentinel and exhaustion.
module segment_rep_counter
  import segment_transition_ctl_pkg::*;
#(
  parameter int RepWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [RepWidth-1:0] load_val,
  input  logic                dec,
  output logic                infinite,
  output logic                exhausted
);

  logic [RepWidth-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RepInfinite[RepWidth-1:0];
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !infinite && !exhausted) begin
      cnt <= cnt - RepWidth'(1);
    end
  end

  assign infinite  = (cnt == RepInfinite[RepWidth-1:0]);
  assign exhausted = (cnt == '0);

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment sequencer: holds the active segment, arms transition requests and
// swaps segments on the selected trigger, with repeat counting and EXT ring mode.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter  int NumSegment = 2,
  parameter  int NumGpio    = 4,
  parameter  int RepWidth   = 16,
  parameter  int TimeWidth  = 64,
  localparam int SegW       = $clog2(NumSegment)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 UPDATE,
  input  logic [SegW-1:0]      REQ_SEGMENT,
  input  logic [7:0]           REQ_MODE,
  input  logic [TimeWidth-1:0] REQ_VALUE,
  input  logic [RepWidth-1:0]  REQ_REP,
  input  logic                 LOOP_END,
  input  logic                 SYNC_IDX_ZERO,
  input  logic [TimeWidth-1:0] SYS_TIME,
  input  logic [NumGpio-1:0]   GPIO_IN,
  output logic [SegW-1:0]      SEGMENT,
  output logic                 START,
  output logic                 STOP,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int GpioIdxW = (NumGpio > 1) ? $clog2(NumGpio) : 1;

  seg_trans_state_t      state;
  logic                  ext_mode;
  logic [SegW-1:0]       req_seg_p0;
  logic [RepWidth-1:0]   req_rep_p0;
  logic [TimeWidth-1:0]  req_time_p0;
  logic [GpioIdxW-1:0]   req_gpio_p0;
  logic                  req_ext_p0;
  logic [NumGpio-1:0]    gpio_p0;

  logic                  upd_ok, upd_imm, trig, wait_sw, run_loop;
  logic                  rep_infinite, rep_exhausted, rep_load, rep_dec;
  logic [RepWidth-1:0]   rep_load_val;
  logic [NumGpio-1:0]    gpio_rise;
  logic [SegW-1:0]       next_seg;

  // Stage p0: request capture and GPIO edge-detect delay
  always_ff @(posedge CLK) begin
    gpio_p0 <= GPIO_IN;
    if (upd_ok) begin
      req_seg_p0  <= REQ_SEGMENT;
      req_rep_p0  <= REQ_REP;
      req_time_p0 <= REQ_VALUE;
      req_gpio_p0 <= REQ_VALUE[GpioIdxW-1:0];
      req_ext_p0  <= (REQ_MODE == TRANSITION_MODE_EXT);
    end
  end

  // A new UPDATE always wins over a trigger or loop end in the same cycle.
  always_comb begin
    gpio_rise = GPIO_IN & ~gpio_p0;
    trig      = 1'b0;
    unique case (state)
      WAIT_SYNC: trig = req_ext_p0 ? LOOP_END : SYNC_IDX_ZERO;
      WAIT_TIME: trig = (SYS_TIME >= req_time_p0);
      WAIT_GPIO: trig = gpio_rise[req_gpio_p0];
      default:   trig = 1'b0;
    endcase
    upd_ok       = UPDATE && mode_known(REQ_MODE);
    upd_imm      = upd_ok && (REQ_MODE == TRANSITION_MODE_IMMEDIATE);
    wait_sw      = !upd_ok && (state != RUN) && trig;
    run_loop     = !upd_ok && (state == RUN) && LOOP_END;
    rep_load     = upd_imm || wait_sw || (run_loop && !rep_infinite && rep_exhausted && ext_mode);
    rep_load_val = upd_imm ? REQ_REP : req_rep_p0;
    rep_dec      = run_loop;
    next_seg     = (SEGMENT == SegW'(NumSegment - 1)) ? '0 : SEGMENT + SegW'(1);
  end

  segment_rep_counter #(.RepWidth(RepWidth)) u_rep (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (rep_load),
    .load_val  (rep_load_val),
    .dec       (rep_dec),
    .infinite  (rep_infinite),
    .exhausted (rep_exhausted)
  );

  // Stage p1: sequencer state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      SEGMENT  <= '0;
      START    <= 1'b0;
      STOP     <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      ext_mode <= 1'b0;
    end else begin
      START <= 1'b0;
      if (UPDATE && !mode_known(REQ_MODE)) begin
        ERR <= 1'b1;
      end
      if (upd_ok) begin
        ext_mode <= 1'b0;
        if (upd_imm) begin
          state   <= RUN;
          BUSY    <= 1'b0;
          SEGMENT <= REQ_SEGMENT;
          START   <= 1'b1;
          STOP    <= 1'b0;
        end else if (REQ_MODE == TRANSITION_MODE_SYS_TIME) begin
          state <= WAIT_TIME;
          BUSY  <= 1'b1;
        end else if (REQ_MODE == TRANSITION_MODE_GPIO) begin
          state <= WAIT_GPIO;
          BUSY  <= 1'b1;
        end else begin
          // SYNC_IDX and EXT both wait on a playback-index event
          state <= WAIT_SYNC;
          BUSY  <= 1'b1;
        end
      end else if (wait_sw) begin
        state    <= RUN;
        BUSY     <= 1'b0;
        SEGMENT  <= req_seg_p0;
        START    <= 1'b1;
        STOP     <= 1'b0;
        ext_mode <= req_ext_p0;
      end else if (run_loop && !rep_infinite && rep_exhausted) begin
        if (ext_mode) begin
          SEGMENT <= next_seg;
          START   <= 1'b1;
        end else begin
          STOP <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl with four segments and
// hand-computed expectations checked by immediate assertions.
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        UPDATE;
  logic [1:0]  REQ_SEGMENT;
  logic [7:0]  REQ_MODE;
  logic [63:0] REQ_VALUE;
  logic [15:0] REQ_REP;
  logic        LOOP_END;
  logic        SYNC_IDX_ZERO;
  logic [63:0] SYS_TIME;
  logic [3:0]  GPIO_IN;
  logic [1:0]  SEGMENT;
  logic        START, STOP, BUSY, ERR;

  int checks   = 0;
  int failures = 0;

  segment_transition_ctl #(
    .NumSegment(4), .NumGpio(4), .RepWidth(16), .TimeWidth(64)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT),
    .REQ_MODE(REQ_MODE), .REQ_VALUE(REQ_VALUE), .REQ_REP(REQ_REP),
    .LOOP_END(LOOP_END), .SYNC_IDX_ZERO(SYNC_IDX_ZERO), .SYS_TIME(SYS_TIME),
    .GPIO_IN(GPIO_IN), .SEGMENT(SEGMENT), .START(START), .STOP(STOP),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic request(input logic [7:0] mode, input logic [1:0] seg,
                         input logic [63:0] value, input logic [15:0] rep);
    UPDATE = 1'b1; REQ_MODE = mode; REQ_SEGMENT = seg; REQ_VALUE = value; REQ_REP = rep;
    step();
    UPDATE = 1'b0;
  endtask

  task automatic loop_pulse();
    LOOP_END = 1'b1;
    step();
    LOOP_END = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = '0; REQ_MODE = '0; REQ_VALUE = '0;
    REQ_REP = '0; LOOP_END = 1'b0; SYNC_IDX_ZERO = 1'b0; SYS_TIME = '0; GPIO_IN = '0;
    step(); step();
    chk("rst_segment", SEGMENT, 0);
    chk("rst_start", START, 0);
    chk("rst_stop", STOP, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    RST_N = 1'b1;
    for (int i = 0; i < 7; i++) step();

    // IMMEDIATE to segment 1, three loops then stop
    request(8'hFF, 2'd1, 64'd0, 16'd2);
    chk("imm_segment", SEGMENT, 1);
    chk("imm_start", START, 1);
    chk("imm_busy", BUSY, 0);
    step();
    chk("imm_start_drop", START, 0);
    loop_pulse(); chk("rep_le1_stop", STOP, 0);
    loop_pulse(); chk("rep_le2_stop", STOP, 0);
    loop_pulse(); chk("rep_le3_stop", STOP, 1);
    chk("rep_le3_segment", SEGMENT, 1);
    loop_pulse();
    chk("rep_le4_stop", STOP, 1);
    chk("rep_le4_segment", SEGMENT, 1);
    chk("rep_le4_start", START, 0);

    // SYS_TIME ramp from 990 to target 1000
    SYS_TIME = 64'd990;
    request(8'h01, 2'd2, 64'd1000, 16'hFFFF);
    chk("time_busy", BUSY, 1);
    for (int t = 991; t <= 1000; t++) begin
      step();
      SYS_TIME = 64'(t);
      chk("time_wait_busy", BUSY, 1);
      chk("time_wait_segment", SEGMENT, 1);
    end
    step();
    chk("time_segment", SEGMENT, 2);
    chk("time_start", START, 1);
    chk("time_busy_clr", BUSY, 0);
    chk("time_stop_clr", STOP, 0);

    // Time already in the past switches two cycles after UPDATE
    SYS_TIME = 64'd2000;
    request(8'h01, 2'd3, 64'd1995, 16'hFFFF);
    chk("past_n1_segment", SEGMENT, 2);
    chk("past_n1_busy", BUSY, 1);
    step();
    chk("past_n2_segment", SEGMENT, 3);
    chk("past_n2_start", START, 1);

    // GPIO index 2 held high at request time
    GPIO_IN = 4'b0100;
    step();
    request(8'h02, 2'd0, 64'd2, 16'hFFFF);
    chk("gpio_busy", BUSY, 1);
    step(); step(); step();
    chk("gpio_held_segment", SEGMENT, 3);
    GPIO_IN = 4'b0101; step();
    GPIO_IN = 4'b0100; step();
    chk("gpio_other_segment", SEGMENT, 3);
    chk("gpio_other_busy", BUSY, 1);
    GPIO_IN = 4'b0000; step();
    chk("gpio_low_segment", SEGMENT, 3);
    GPIO_IN = 4'b0100; step();
    chk("gpio_rise_segment", SEGMENT, 0);
    chk("gpio_rise_start", START, 1);
    chk("gpio_rise_busy", BUSY, 0);
    GPIO_IN = 4'b0000;

    // EXT ring: target 3, one loop per segment
    request(8'hF0, 2'd3, 64'd0, 16'd0);
    chk("ext_busy", BUSY, 1);
    chk("ext_wait_segment", SEGMENT, 0);
    loop_pulse(); chk("ext_seg0", SEGMENT, 3); chk("ext_start0", START, 1);
    step();       chk("ext_idle0", START, 0);
    loop_pulse(); chk("ext_seg1", SEGMENT, 0); chk("ext_start1", START, 1);
    step();       chk("ext_idle1", START, 0);
    loop_pulse(); chk("ext_seg2", SEGMENT, 1); chk("ext_start2", START, 1);
    step();
    loop_pulse(); chk("ext_seg3", SEGMENT, 2); chk("ext_start3", START, 1);
    step();
    loop_pulse(); chk("ext_seg4", SEGMENT, 3); chk("ext_start4", START, 1);
    chk("ext_stop", STOP, 0);
    chk("ext_busy_clr", BUSY, 0);

    // SYNC request overridden by IMMEDIATE before the sync pulse
    request(8'h00, 2'd1, 64'd0, 16'hFFFF);
    chk("sync_busy", BUSY, 1);
    chk("sync_wait_segment", SEGMENT, 3);
    step();
    request(8'hFF, 2'd0, 64'd0, 16'hFFFF);
    chk("override_segment", SEGMENT, 0);
    chk("override_start", START, 1);
    chk("override_busy", BUSY, 0);
    SYNC_IDX_ZERO = 1'b1; step(); SYNC_IDX_ZERO = 1'b0;
    chk("stale_sync_segment", SEGMENT, 0);
    chk("stale_sync_start", START, 0);

    // Unknown mode code
    request(8'h37, 2'd2, 64'd0, 16'hFFFF);
    chk("unk_err", ERR, 1);
    chk("unk_segment", SEGMENT, 0);
    chk("unk_busy", BUSY, 0);
    step();
    chk("unk_err_sticky", ERR, 1);

    // Same-segment IMMEDIATE request still pulses START
    request(8'hFF, 2'd0, 64'd0, 16'hFFFF);
    chk("same_start", START, 1);
    chk("same_segment", SEGMENT, 0);

    // Asynchronous reset while waiting on time
    request(8'hFF, 2'd2, 64'd0, 16'hFFFF);
    SYS_TIME = 64'd3000;
    request(8'h01, 2'd1, 64'd3005, 16'hFFFF);
    chk("rst_wait_busy", BUSY, 1);
    chk("rst_wait_segment", SEGMENT, 2);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_segment", SEGMENT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_err", ERR, 0);
    chk("arst_start", START, 0);
    chk("arst_stop", STOP, 0);
    step();
    RST_N = 1'b1;
    for (int t = 3001; t <= 3010; t++) begin
      SYS_TIME = 64'(t);
      step();
    end
    chk("post_rst_segment", SEGMENT, 0);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_start", START, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
